// File: rtl/id_ex_pipeline_stage.sv
// id_ex_pipeline_stage
// ID/EX pipeline register with load-use hazard detection.
// Captures forwarded operands, immediate, control bundle and instruction for EX.
// A load in EX whose destination is read by the ID instruction causes a
// one-cycle stall plus a bubble. A taken-branch flush turns the ID slot into a
// bubble and takes priority over the hazard.
// Optional feature macro: ID_EX_STAT_EN adds saturating stall/flush counters.
module id_ex_pipeline_stage #(
    parameter int DATA_W  = 64,
    parameter int INSTR_W = 32,
    parameter int CTRL_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ID_valid,
    input  logic [INSTR_W-1:0] ID_instruction,
    input  logic               ID_Reg2Loc,
    input  logic [DATA_W-1:0]  Da_forwarded,
    input  logic [DATA_W-1:0]  Db_forwarded,
    input  logic [DATA_W-1:0]  ID_imm,
    input  logic [CTRL_W-1:0]  ID_ctrl,
    input  logic               flush,
    output logic               stall,
    output logic               EX_valid,
    output logic [INSTR_W-1:0] EX_instruction,
    output logic [DATA_W-1:0]  EX_Da,
    output logic [DATA_W-1:0]  EX_Db,
    output logic [DATA_W-1:0]  EX_imm,
    output logic [CTRL_W-1:0]  EX_ctrl
`ifdef ID_EX_STAT_EN
    ,
    output logic [31:0]        stall_count,
    output logic [31:0]        flush_count
`endif
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_BUBBLE = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic                 ex_valid_q, ex_valid_d;
    logic [INSTR_W-1:0]   ex_instruction_q, ex_instruction_d;
    logic [DATA_W-1:0]    ex_da_q, ex_da_d;
    logic [DATA_W-1:0]    ex_db_q, ex_db_d;
    logic [DATA_W-1:0]    ex_imm_q, ex_imm_d;
    logic [CTRL_W-1:0]    ex_ctrl_q, ex_ctrl_d;

    logic [4:0]           ex_rd_s;
    logic [4:0]           id_rn_s;
    logic [4:0]           id_rb_s;
    logic                 hz_s;
    logic                 stall_s;

    // True when a valid load in EX writes a real register that ID reads.
    function automatic logic load_use(
        input logic       ex_valid,
        input logic       ex_mem_read,
        input logic       ex_reg_write,
        input logic [4:0] ex_rd,
        input logic       id_valid,
        input logic [4:0] id_rn,
        input logic [4:0] id_rb
    );
        load_use = ex_valid & ex_mem_read & ex_reg_write & (ex_rd != 5'd31)
                 & id_valid & ((ex_rd == id_rn) | (ex_rd == id_rb));
    endfunction

    // Hazard detection and stall request from registered EX fields and ID inputs.
    always_comb begin
        ex_rd_s = ex_instruction_q[4:0];
        id_rn_s = ID_instruction[9:5];
        if (ID_Reg2Loc) begin
            id_rb_s = ID_instruction[20:16];
        end else begin
            id_rb_s = ID_instruction[4:0];
        end
        hz_s    = load_use(ex_valid_q, ex_ctrl_q[1], ex_ctrl_q[0], ex_rd_s,
                           ID_valid, id_rn_s, id_rb_s);
        // The stall is only raised from RUN, so one load stalls at most once.
        stall_s = ~reset & (state_q == ST_RUN) & ~flush & hz_s;
    end

    // Next-state and next EX contents: flush > hazard > normal capture.
    always_comb begin
        state_d          = ST_RUN;
        ex_valid_d       = 1'b0;
        ex_instruction_d = {INSTR_W{1'b0}};
        ex_da_d          = {DATA_W{1'b0}};
        ex_db_d          = {DATA_W{1'b0}};
        ex_imm_d         = {DATA_W{1'b0}};
        ex_ctrl_d        = {CTRL_W{1'b0}};
        case (state_q)
            ST_RUN, ST_BUBBLE: begin
                if (flush) begin
                    state_d = ST_RUN;
                end else if ((state_q == ST_RUN) && hz_s) begin
                    state_d = ST_BUBBLE;
                end else begin
                    // In BUBBLE the stalled instruction is re-captured; its
                    // load has reached MA so forwarding now supplies the data.
                    state_d          = ST_RUN;
                    ex_valid_d       = ID_valid;
                    ex_instruction_d = ID_instruction;
                    ex_da_d          = Da_forwarded;
                    ex_db_d          = Db_forwarded;
                    ex_imm_d         = ID_imm;
                    if (ID_valid) begin
                        ex_ctrl_d = ID_ctrl;
                    end else begin
                        ex_ctrl_d = {CTRL_W{1'b0}};
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // FSM state and EX register bank.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= ST_RUN;
            ex_valid_q       <= 1'b0;
            ex_instruction_q <= {INSTR_W{1'b0}};
            ex_da_q          <= {DATA_W{1'b0}};
            ex_db_q          <= {DATA_W{1'b0}};
            ex_imm_q         <= {DATA_W{1'b0}};
            ex_ctrl_q        <= {CTRL_W{1'b0}};
        end else begin
            state_q          <= state_d;
            ex_valid_q       <= ex_valid_d;
            ex_instruction_q <= ex_instruction_d;
            ex_da_q          <= ex_da_d;
            ex_db_q          <= ex_db_d;
            ex_imm_q         <= ex_imm_d;
            ex_ctrl_q        <= ex_ctrl_d;
        end
    end

    assign stall          = stall_s;
    assign EX_valid       = ex_valid_q;
    assign EX_instruction = ex_instruction_q;
    assign EX_Da          = ex_da_q;
    assign EX_Db          = ex_db_q;
    assign EX_imm         = ex_imm_q;
    assign EX_ctrl        = ex_ctrl_q;

`ifdef ID_EX_STAT_EN
    logic [31:0] stall_count_q, stall_count_d;
    logic [31:0] flush_count_q, flush_count_d;

    // Saturating event counters for stall and flush cycles.
    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (stall_s && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end else begin
            stall_count_d = stall_count_q;
        end
        if (flush && (flush_count_q != 32'hFFFF_FFFF)) begin
            flush_count_d = flush_count_q + 32'd1;
        end else begin
            flush_count_d = flush_count_q;
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_q <= 32'd0;
            flush_count_q <= 32'd0;
        end else begin
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_id_ex_pipeline_stage.sv
// Scoreboard bench for id_ex_pipeline_stage: the driver applies one directed
// vector per cycle and queues the hand-computed stall (same cycle) and EX
// contents (after the next rising edge); a monitor pops and compares.
module tb_id_ex_pipeline_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ID_valid;
    logic [31:0] ID_instruction;
    logic        ID_Reg2Loc;
    logic [63:0] Da_forwarded;
    logic [63:0] Db_forwarded;
    logic [63:0] ID_imm;
    logic [7:0]  ID_ctrl;
    logic        flush;
    logic        stall;
    logic        EX_valid;
    logic [31:0] EX_instruction;
    logic [63:0] EX_Da;
    logic [63:0] EX_Db;
    logic [63:0] EX_imm;
    logic [7:0]  EX_ctrl;
`ifdef ID_EX_STAT_EN
    logic [31:0] stall_count;
    logic [31:0] flush_count;
`endif

    id_ex_pipeline_stage #(.DATA_W(64), .INSTR_W(32), .CTRL_W(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .ID_valid       (ID_valid),
        .ID_instruction (ID_instruction),
        .ID_Reg2Loc     (ID_Reg2Loc),
        .Da_forwarded   (Da_forwarded),
        .Db_forwarded   (Db_forwarded),
        .ID_imm         (ID_imm),
        .ID_ctrl        (ID_ctrl),
        .flush          (flush),
        .stall          (stall),
        .EX_valid       (EX_valid),
        .EX_instruction (EX_instruction),
        .EX_Da          (EX_Da),
        .EX_Db          (EX_Db),
        .EX_imm         (EX_imm),
        .EX_ctrl        (EX_ctrl)
`ifdef ID_EX_STAT_EN
        ,
        .stall_count    (stall_count),
        .flush_count    (flush_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        v;
        logic [31:0] ins;
        logic [63:0] da;
        logic [63:0] db;
        logic [63:0] imm;
        logic [7:0]  ctrl;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] mk(input logic [4:0] rm, input logic [4:0] rn, input logic [4:0] rd);
        mk = {11'd0, rm, 6'd0, rn, rd};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic v, input logic [31:0] ins, input logic r2l,
                         input logic [63:0] da, input logic [63:0] db, input logic [63:0] imm,
                         input logic [7:0] ctrl, input logic fl);
        @(negedge clk);
        reset          = rst;
        ID_valid       = v;
        ID_instruction = ins;
        ID_Reg2Loc     = r2l;
        Da_forwarded   = da;
        Db_forwarded   = db;
        ID_imm         = imm;
        ID_ctrl        = ctrl;
        flush          = fl;
    endtask

    task automatic expect_ex(input logic st, input logic v, input logic [31:0] ins,
                             input logic [63:0] da, input logic [63:0] db, input logic [63:0] imm,
                             input logic [7:0] ctrl, input logic [31:0] sc, input logic [31:0] fc);
        exp_t e;
        e.st = st; e.v = v; e.ins = ins; e.da = da; e.db = db; e.imm = imm;
        e.ctrl = ctrl; e.sc = sc; e.fc = fc;
        q.push_back(e);
    endtask

    task automatic expect_bubble(input logic st, input logic [31:0] sc, input logic [31:0] fc);
        expect_ex(st, 1'b0, 32'd0, 64'd0, 64'd0, 64'd0, 8'd0, sc, fc);
    endtask

    // Monitor: stall checked mid-cycle, EX bundle checked just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q[0];
                chk("stall", {63'd0, stall}, {63'd0, e.st});
                @(posedge clk);
                #1;
                chk("EX_valid", {63'd0, EX_valid}, {63'd0, e.v});
                chk("EX_instruction", {32'd0, EX_instruction}, {32'd0, e.ins});
                chk("EX_Da", EX_Da, e.da);
                chk("EX_Db", EX_Db, e.db);
                chk("EX_imm", EX_imm, e.imm);
                chk("EX_ctrl", {56'd0, EX_ctrl}, {56'd0, e.ctrl});
`ifdef ID_EX_STAT_EN
                chk("stall_count", {32'd0, stall_count}, {32'd0, e.sc});
                chk("flush_count", {32'd0, flush_count}, {32'd0, e.fc});
`endif
                void'(q.pop_front());
            end
        end
    end

    // Directed stimulus with hand-computed expectations.
    initial begin
        logic [31:0] a_i, l5_i, u_i, b_i, l7_i, r_i, l31_i, q_i, c_i, d_i;
        int wait_cycles;
        a_i   = mk(5'd1, 5'd2, 5'd3);
        l5_i  = mk(5'd0, 5'd0, 5'd5);
        u_i   = mk(5'd9, 5'd5, 5'd1);
        b_i   = mk(5'd4, 5'd4, 5'd4);
        l7_i  = mk(5'd0, 5'd0, 5'd7);
        r_i   = mk(5'd3, 5'd1, 5'd7);
        l31_i = mk(5'd0, 5'd0, 5'd31);
        q_i   = mk(5'd31, 5'd31, 5'd31);
        c_i   = mk(5'd2, 5'd2, 5'd2);
        d_i   = mk(5'd5, 5'd5, 5'd5);

        reset = 1'b1; ID_valid = 1'b0; ID_instruction = 32'd0; ID_Reg2Loc = 1'b0;
        Da_forwarded = 64'd0; Db_forwarded = 64'd0; ID_imm = 64'd0; ID_ctrl = 8'd0; flush = 1'b0;

        // Reset for two cycles with arbitrary inputs (flush ignored under reset).
        drive(1'b1, 1'b1, mk(5'd5, 5'd5, 5'd5), 1'b1, 64'h1111, 64'h2222, 64'h3333, 8'hFF, 1'b0);
        expect_bubble(1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b1, mk(5'd7, 5'd7, 5'd7), 1'b0, 64'h4444, 64'h5555, 64'h6666, 8'h03, 1'b1);
        expect_bubble(1'b0, 32'd0, 32'd0);
        // Pass-through.
        drive(1'b0, 1'b1, a_i, 1'b0, 64'hBEEF, 64'hCAFE, 64'h10, 8'h01, 1'b0);
        expect_ex(1'b0, 1'b1, a_i, 64'hBEEF, 64'hCAFE, 64'h10, 8'h01, 32'd0, 32'd0);
        // Load X5 enters EX, then consumer with Rn=5 stalls, then re-captured.
        drive(1'b0, 1'b1, l5_i, 1'b0, 64'h11, 64'h22, 64'h8, 8'h03, 1'b0);
        expect_ex(1'b0, 1'b1, l5_i, 64'h11, 64'h22, 64'h8, 8'h03, 32'd0, 32'd0);
        drive(1'b0, 1'b1, u_i, 1'b1, 64'h33, 64'h44, 64'h18, 8'h01, 1'b0);
        expect_bubble(1'b1, 32'd1, 32'd0);
        drive(1'b0, 1'b1, u_i, 1'b1, 64'h55, 64'h44, 64'h18, 8'h01, 1'b0);
        expect_ex(1'b0, 1'b1, u_i, 64'h55, 64'h44, 64'h18, 8'h01, 32'd1, 32'd0);
        // ID_valid=0: fields captured, valid and ctrl forced low.
        drive(1'b0, 1'b0, b_i, 1'b0, 64'h66, 64'h77, 64'h88, 8'h7F, 1'b0);
        expect_ex(1'b0, 1'b0, b_i, 64'h66, 64'h77, 64'h88, 8'h00, 32'd1, 32'd0);
        // Load X7; ID Rd=7 Rm=3 with Reg2Loc=1 -> no stall.
        drive(1'b0, 1'b1, l7_i, 1'b0, 64'h70, 64'h71, 64'h72, 8'h03, 1'b0);
        expect_ex(1'b0, 1'b1, l7_i, 64'h70, 64'h71, 64'h72, 8'h03, 32'd1, 32'd0);
        drive(1'b0, 1'b1, r_i, 1'b1, 64'h80, 64'h81, 64'h82, 8'h05, 1'b0);
        expect_ex(1'b0, 1'b1, r_i, 64'h80, 64'h81, 64'h82, 8'h05, 32'd1, 32'd0);
        // Load X7 again; same ID with Reg2Loc=0 -> stall.
        drive(1'b0, 1'b1, l7_i, 1'b0, 64'h70, 64'h71, 64'h72, 8'h03, 1'b0);
        expect_ex(1'b0, 1'b1, l7_i, 64'h70, 64'h71, 64'h72, 8'h03, 32'd1, 32'd0);
        drive(1'b0, 1'b1, r_i, 1'b0, 64'h80, 64'h81, 64'h82, 8'h05, 1'b0);
        expect_bubble(1'b1, 32'd2, 32'd0);
        drive(1'b0, 1'b1, r_i, 1'b0, 64'h90, 64'h81, 64'h82, 8'h05, 1'b0);
        expect_ex(1'b0, 1'b1, r_i, 64'h90, 64'h81, 64'h82, 8'h05, 32'd2, 32'd0);
        // Load to X31 never stalls.
        drive(1'b0, 1'b1, l31_i, 1'b0, 64'hA0, 64'hA1, 64'hA2, 8'h03, 1'b0);
        expect_ex(1'b0, 1'b1, l31_i, 64'hA0, 64'hA1, 64'hA2, 8'h03, 32'd2, 32'd0);
        drive(1'b0, 1'b1, q_i, 1'b0, 64'hB0, 64'hB1, 64'hB2, 8'h01, 1'b0);
        expect_ex(1'b0, 1'b1, q_i, 64'hB0, 64'hB1, 64'hB2, 8'h01, 32'd2, 32'd0);
        // Flush beats hazard.
        drive(1'b0, 1'b1, l5_i, 1'b0, 64'h11, 64'h22, 64'h8, 8'h03, 1'b0);
        expect_ex(1'b0, 1'b1, l5_i, 64'h11, 64'h22, 64'h8, 8'h03, 32'd2, 32'd0);
        drive(1'b0, 1'b1, u_i, 1'b1, 64'h33, 64'h44, 64'h18, 8'h01, 1'b1);
        expect_bubble(1'b0, 32'd2, 32'd1);
        drive(1'b0, 1'b1, c_i, 1'b0, 64'hC0, 64'hC1, 64'hC2, 8'hA1, 1'b0);
        expect_ex(1'b0, 1'b1, c_i, 64'hC0, 64'hC1, 64'hC2, 8'hA1, 32'd2, 32'd1);
        // Reset during the BUBBLE cycle discards the stalled instruction.
        drive(1'b0, 1'b1, l5_i, 1'b0, 64'h11, 64'h22, 64'h8, 8'h03, 1'b0);
        expect_ex(1'b0, 1'b1, l5_i, 64'h11, 64'h22, 64'h8, 8'h03, 32'd2, 32'd1);
        drive(1'b0, 1'b1, u_i, 1'b1, 64'h33, 64'h44, 64'h18, 8'h01, 1'b0);
        expect_bubble(1'b1, 32'd3, 32'd1);
        drive(1'b1, 1'b1, u_i, 1'b1, 64'h55, 64'h44, 64'h18, 8'h01, 1'b0);
        expect_bubble(1'b0, 32'd0, 32'd0);
        drive(1'b0, 1'b0, 32'd0, 1'b0, 64'd0, 64'd0, 64'd0, 8'd0, 1'b0);
        expect_bubble(1'b0, 32'd0, 32'd0);
        drive(1'b0, 1'b1, d_i, 1'b0, 64'hD0, 64'hD1, 64'hD2, 8'h01, 1'b0);
        expect_ex(1'b0, 1'b1, d_i, 64'hD0, 64'hD1, 64'hD2, 8'h01, 32'd0, 32'd0);
        drive(1'b0, 1'b0, 32'd0, 1'b0, 64'd0, 64'd0, 64'd0, 8'd0, 1'b0);
        expect_bubble(1'b0, 32'd0, 32'd0);

        wait_cycles = 0;
        while ((q.size() > 0) && (wait_cycles < 20)) begin
            @(posedge clk);
            wait_cycles++;
        end
        #3;
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain actual=%0d pending required=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
